// File: rtl/mac_neuron_pkg.sv
// Shared types and constants for the MAC neuron: FSM states, activation
// selectors and the fixed-point mapping used by the activation stage.
package mac_neuron_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    ACT   = 2'd2,
    DONE  = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    ACT_TANH     = 2'd0,
    ACT_RELU     = 2'd1,
    ACT_LIN      = 2'd2,
    ACT_LIN_ALT  = 2'd3
  } act_mode_t;

  localparam int SAT_THRESH = 1024;
  localparam int MAG_SHIFT  = 2;
  localparam int Q_W        = 9;

endpackage

// File: rtl/neuron_act.sv
// Activation stage: folds the accumulator to a sign plus 8-bit magnitude and
// applies tanh, relu or linear mapping. Purely combinational.
module neuron_act
  import mac_neuron_pkg::*;
#(
  parameter int ACC_W = 26
)(
  input  logic signed [ACC_W-1:0] acc,
  input  act_mode_t               mode,
  output logic [Q_W-1:0]          q
);

  localparam int AW = ACC_W + 1;

  logic          neg;
  logic [AW-1:0] ext;
  logic [AW-1:0] mag_full;
  logic [7:0]    m;
  logic [7:0]    lut_y;
  logic [7:0]    mag_sel;
  logic          sign_sel;

  tanh_lut8 u_lut (
    .x (m),
    .y (lut_y)
  );

  // One extra bit keeps |most-negative| representable.
  always_comb begin
    neg      = acc[ACC_W-1];
    ext      = {acc[ACC_W-1], acc};
    mag_full = neg ? (~ext + AW'(1)) : ext;
    m        = (mag_full >= AW'(SAT_THRESH)) ? 8'hFF : mag_full[MAG_SHIFT +: 8];
    sign_sel = neg;
    mag_sel  = m;
    case (mode)
      ACT_TANH: mag_sel = lut_y;
      ACT_RELU: begin
        sign_sel = 1'b0;
        mag_sel  = neg ? 8'd0 : m;
      end
      default: ;
    endcase
    q = {sign_sel && (mag_sel != 8'd0), mag_sel};
  end

endmodule

// File: rtl/tanh_lut8.sv
// 8-bit tanh table: y ~= 255 * tanh(x / 64), built from 17 knots spaced
// 16 apart with linear interpolation between neighbouring knots.
module tanh_lut8 (
  input  logic [7:0] x,
  output logic [7:0] y
);

  function automatic logic [7:0] knot(input logic [4:0] i);
    case (i)
      5'd0:  knot = 8'd0;
      5'd1:  knot = 8'd62;
      5'd2:  knot = 8'd118;
      5'd3:  knot = 8'd162;
      5'd4:  knot = 8'd194;
      5'd5:  knot = 8'd216;
      5'd6:  knot = 8'd231;
      5'd7:  knot = 8'd240;
      5'd8:  knot = 8'd246;
      5'd9:  knot = 8'd249;
      5'd10: knot = 8'd252;
      5'd11: knot = 8'd253;
      5'd12: knot = 8'd254;
      5'd13: knot = 8'd254;
      default: knot = 8'd255;
    endcase
  endfunction

  logic [7:0]  lo;
  logic [7:0]  hi;
  logic [11:0] span;

  // Knots are monotone, so hi - lo never underflows and lo + span stays <= 255.
  always_comb begin
    lo   = knot({1'b0, x[7:4]});
    hi   = knot({1'b0, x[7:4]} + 5'd1);
    span = 12'(hi - lo) * 12'(x[3:0]);
    y    = lo + span[11:4];
  end

endmodule

// File: rtl/mac_neuron.sv
// Single neuron: streams LANES inputs per beat through a saturating signed
// MAC seeded with the bias, then maps the sum through a selectable activation.
module mac_neuron
  import mac_neuron_pkg::*;
#(
  parameter int INPUTS = 400,
  parameter int LANES  = 5,
  parameter int D_W    = 8,
  parameter int W_W    = 9,
  parameter int ACC_W  = 26
)(
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          wr_weights,
  input  logic [INPUTS-1:0][W_W-1:0]    weights_d,
  input  logic [W_W-1:0]                bias_d,
  input  logic [1:0]                    act_mode,
  input  logic                          start,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [LANES-1:0][D_W-1:0]     d,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [Q_W-1:0]                q,
  output logic                          busy
);

  localparam int CNT_W  = $clog2(INPUTS + LANES);
  localparam int IDX_W  = (INPUTS > 1) ? $clog2(INPUTS) : 1;
  localparam int PROD_W = D_W + 1 + W_W;
  localparam int BEAT_W = PROD_W + $clog2(LANES) + 1;
  localparam int SUM_W  = ((ACC_W > BEAT_W) ? ACC_W : BEAT_W) + 1;

  localparam logic signed [SUM_W-1:0] ACC_MAX =
    $signed({{(SUM_W-ACC_W+1){1'b0}}, {(ACC_W-1){1'b1}}});
  localparam logic signed [SUM_W-1:0] ACC_MIN =
    $signed({{(SUM_W-ACC_W+1){1'b1}}, {(ACC_W-1){1'b0}}});

  state_t                       state;
  state_t                       state_next;
  act_mode_t                    mode;
  logic [INPUTS-1:0][W_W-1:0]   weights;
  logic [W_W-1:0]               bias;
  logic signed [ACC_W-1:0]      acc;
  logic [CNT_W-1:0]             cnt;
  logic [CNT_W-1:0]             cnt_step;
  logic                         beat;
  logic                         last_beat;
  logic signed [BEAT_W-1:0]     beat_sum;
  logic [CNT_W-1:0]             idx;
  logic signed [W_W-1:0]        w_k;
  logic signed [D_W:0]          d_k;
  logic signed [PROD_W-1:0]     prod_k;
  logic [Q_W-1:0]               act_q;

  function automatic logic signed [ACC_W-1:0] sat_add(
    input logic signed [ACC_W-1:0]  a,
    input logic signed [BEAT_W-1:0] b
  );
    logic signed [SUM_W-1:0] s;
    s = SUM_W'(a) + SUM_W'(b);
    if (s > ACC_MAX)      sat_add = ACC_MAX[ACC_W-1:0];
    else if (s < ACC_MIN) sat_add = ACC_MIN[ACC_W-1:0];
    else                  sat_add = s[ACC_W-1:0];
  endfunction

  // Lanes past the last real input (ragged final beat) contribute zero.
  always_comb begin
    beat_sum = '0;
    idx      = '0;
    w_k      = '0;
    d_k      = '0;
    prod_k   = '0;
    for (int k = 0; k < LANES; k++) begin
      idx = cnt + CNT_W'(k);
      if (idx < CNT_W'(INPUTS)) w_k = $signed(weights[idx[IDX_W-1:0]]);
      else                      w_k = '0;
      d_k      = $signed({1'b0, d[k]});
      prod_k   = PROD_W'(d_k) * PROD_W'(w_k);
      beat_sum = beat_sum + BEAT_W'(prod_k);
    end
  end

  assign beat      = in_valid && in_ready;
  assign cnt_step  = cnt + CNT_W'(LANES);
  assign last_beat = beat && (cnt_step >= CNT_W'(INPUTS));

  neuron_act #(.ACC_W(ACC_W)) u_act (
    .acc  (acc),
    .mode (mode),
    .q    (act_q)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start && !wr_weights) state_next = ACCUM;
      ACCUM:   if (last_beat)            state_next = ACT;
      ACT:                               state_next = DONE;
      DONE:    if (out_ready)            state_next = IDLE;
      default:                           state_next = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == ACCUM);
    out_valid = (state == DONE);
    busy      = (state != IDLE);
  end

  // Datapath registers: weight store, accumulator, beat counter, result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      weights <= '0;
      bias    <= '0;
      acc     <= '0;
      cnt     <= '0;
      mode    <= ACT_TANH;
      q       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (wr_weights) begin
            weights <= weights_d;
            bias    <= bias_d;
          end else if (start) begin
            acc  <= ACC_W'($signed(bias));
            cnt  <= '0;
            mode <= act_mode_t'(act_mode);
          end
        end
        ACCUM: begin
          if (beat) begin
            acc <= sat_add(acc, beat_sum);
            cnt <= cnt_step;
          end
        end
        ACT:     q <= act_q;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mac_neuron.sv
// Bench for mac_neuron: two instances (10 and 7 inputs, 5 lanes) driven by
// directed and random evaluations, checked against a behavioural model.
module tb_mac_neuron;
  localparam int LN = 5;
  localparam int NI0 = 10;
  localparam int NI1 = 7;
  localparam longint AMAX = (longint'(1) << 25) - 1;
  localparam longint AMIN = -(longint'(1) << 25);

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic            wr[2], st[2], iv[2], orr[2], ir[2], ov[2], bz[2];
  logic [1:0]      am[2];
  logic [8:0]      bd[2], qq[2];
  logic [4:0][7:0] dd[2];
  logic [8:0]      tw[2][10];
  logic [NI0-1:0][8:0] wd0;
  logic [NI1-1:0][8:0] wd1;

  always_comb begin
    for (int k = 0; k < NI0; k++) wd0[k] = tw[0][k];
    for (int k = 0; k < NI1; k++) wd1[k] = tw[1][k];
  end

  mac_neuron #(.INPUTS(NI0), .LANES(LN), .D_W(8), .W_W(9), .ACC_W(26)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .wr_weights(wr[0]), .weights_d(wd0), .bias_d(bd[0]),
    .act_mode(am[0]), .start(st[0]), .in_valid(iv[0]), .in_ready(ir[0]), .d(dd[0]),
    .out_valid(ov[0]), .out_ready(orr[0]), .q(qq[0]), .busy(bz[0])
  );

  mac_neuron #(.INPUTS(NI1), .LANES(LN), .D_W(8), .W_W(9), .ACC_W(26)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .wr_weights(wr[1]), .weights_d(wd1), .bias_d(bd[1]),
    .act_mode(am[1]), .start(st[1]), .in_valid(iv[1]), .in_ready(ir[1]), .d(dd[1]),
    .out_valid(ov[1]), .out_ready(orr[1]), .q(qq[1]), .busy(bz[1])
  );

  int checks = 0;
  int failures = 0;

  // Model state: weights/bias as loaded, running sum, inputs consumed, and
  // which step of an evaluation each instance is in (0 idle, 1 taking
  // inputs, 2 activation cycle, 3 result presented).
  int         nin[2] = '{NI0, NI1};
  int         mw[2][10];
  int         mb[2];
  longint     macc[2];
  int         mcnt[2];
  int         mmode[2];
  int         phase[2] = '{0, 0};
  bit         fresh[2];
  logic [8:0] held[2];
  logic [8:0] last_q[2];

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_tol(input string nm, input int act, input int exp, input int tol);
    checks++;
    if (act > exp + tol || act < exp - tol) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (+/-%0d) at %0t", nm, act, exp, tol, $time);
    end
  endtask

  function automatic longint clamp(input longint v);
    if (v > AMAX) return AMAX;
    if (v < AMIN) return AMIN;
    return v;
  endfunction

  task automatic check_result(input int i);
    longint ab;
    int m, em, ex;
    ab = (macc[i] < 0) ? -macc[i] : macc[i];
    m  = (ab >= 1024) ? 255 : int'(ab / 4);
    case (mmode[i])
      0: begin
        em = int'(255.0 * $tanh(real'(m) / 64.0));
        chk("tanh_sign", longint'(qq[i][8]), longint'((macc[i] < 0 && m != 0) ? 1 : 0));
        chk_tol("tanh_mag", int'(qq[i][7:0]), em, 4);
      end
      1: begin
        ex = (macc[i] < 0) ? 0 : m;
        chk("relu_q", longint'(qq[i]), longint'(ex));
      end
      default: begin
        ex = ((macc[i] < 0 && m != 0) ? 256 : 0) + m;
        chk("linear_q", longint'(qq[i]), longint'(ex));
      end
    endcase
  endtask

  // Observes inputs on the falling edge; the state advance modelled here is
  // what the next rising edge must produce.
  task automatic mon(input int i);
    longint bs;
    if (!rst_n) begin
      phase[i] = 0;
      mb[i] = 0;
      macc[i] = 0;
      for (int k = 0; k < 10; k++) mw[i][k] = 0;
      chk("rst_busy", longint'(bz[i]), 0);
      chk("rst_out_valid", longint'(ov[i]), 0);
      chk("rst_in_ready", longint'(ir[i]), 0);
      chk("rst_q", longint'(qq[i]), 0);
      return;
    end
    case (phase[i])
      0: begin
        chk("idle_busy", longint'(bz[i]), 0);
        chk("idle_in_ready", longint'(ir[i]), 0);
        chk("idle_out_valid", longint'(ov[i]), 0);
        if (wr[i]) begin
          for (int k = 0; k < nin[i]; k++) mw[i][k] = int'($signed(tw[i][k]));
          mb[i] = int'($signed(bd[i]));
        end else if (st[i]) begin
          macc[i] = longint'(mb[i]);
          mcnt[i] = 0;
          mmode[i] = int'(am[i]);
          phase[i] = 1;
        end
      end
      1: begin
        chk("accum_busy", longint'(bz[i]), 1);
        chk("accum_in_ready", longint'(ir[i]), 1);
        chk("accum_out_valid", longint'(ov[i]), 0);
        if (iv[i]) begin
          bs = 0;
          for (int k = 0; k < LN; k++)
            if (mcnt[i] + k < nin[i]) bs += longint'(dd[i][k]) * longint'(mw[i][mcnt[i] + k]);
          macc[i] = clamp(macc[i] + bs);
          mcnt[i] += LN;
          if (mcnt[i] >= nin[i]) phase[i] = 2;
        end
      end
      2: begin
        chk("act_busy", longint'(bz[i]), 1);
        chk("act_in_ready", longint'(ir[i]), 0);
        chk("act_out_valid", longint'(ov[i]), 0);
        phase[i] = 3;
        fresh[i] = 1'b1;
      end
      default: begin
        chk("done_out_valid", longint'(ov[i]), 1);
        chk("done_in_ready", longint'(ir[i]), 0);
        chk("done_busy", longint'(bz[i]), 1);
        if (fresh[i]) begin
          check_result(i);
          held[i] = qq[i];
          last_q[i] = qq[i];
          fresh[i] = 1'b0;
        end else begin
          chk("q_stable", longint'(qq[i]), longint'(held[i]));
        end
        if (orr[i]) phase[i] = 0;
      end
    endcase
  endtask

  always @(negedge clk) begin
    mon(0);
    mon(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input int i, input bit rnd, input int w, input int b);
    for (int k = 0; k < 10; k++)
      tw[i][k] = rnd ? 9'(int'($urandom_range(0, 2 * w)) - w) : 9'(w);
    bd[i] = 9'(b);
    wr[i] = 1'b1;
    tick();
    wr[i] = 1'b0;
  endtask

  // gap: 0 back-to-back beats, 1 one idle cycle before each beat, 2 random.
  task automatic run(input int i, input int mode, input int dval, input int dmax,
                     input int gap, input int hold, input bit poke);
    int nb, t, ng;
    nb = (nin[i] + LN - 1) / LN;
    am[i] = 2'(mode);
    st[i] = 1'b1;
    tick();
    st[i] = 1'b0;
    for (int b = 0; b < nb; b++) begin
      ng = (gap == 2) ? int'($urandom_range(0, 2)) : gap;
      for (int g = 0; g < ng; g++) begin
        iv[i] = 1'b0;
        tick();
      end
      for (int k = 0; k < LN; k++)
        dd[i][k] = (dval >= 0) ? 8'(dval) : 8'($urandom_range(0, dmax));
      iv[i] = 1'b1;
      if (poke && b == 0) begin
        st[i] = 1'b1;
        wr[i] = 1'b1;
        for (int k = 0; k < 10; k++) tw[i][k] = 9'd5;
      end
      tick();
      iv[i] = 1'b0;
      st[i] = 1'b0;
      wr[i] = 1'b0;
    end
    t = 0;
    while (!ov[i] && t < 20) begin
      tick();
      t++;
    end
    chk("out_valid_arrives", longint'(ov[i]), 1);
    for (int h = 0; h < hold; h++) begin
      st[i] = 1'b1;
      iv[i] = 1'b1;
      tick();
    end
    st[i] = 1'b0;
    iv[i] = 1'b0;
    orr[i] = 1'b1;
    tick();
    orr[i] = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int wmax, dmax, b;
    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      wr[i] = 0; st[i] = 0; iv[i] = 0; orr[i] = 0; am[i] = 0; bd[i] = 0; dd[i] = '0;
      for (int k = 0; k < 10; k++) tw[i][k] = '0;
    end
    repeat (3) tick();
    rst_n = 1'b1;
    tick();

    load(0, 0, 1, 0);
    run(0, 2, 4, 0, 0, 0, 0);
    chk("lin_acc_model", macc[0], 40);
    chk("lin_q", longint'(last_q[0]), 'h00A);
    run(0, 0, 4, 0, 0, 0, 0);
    chk_tol("tanh_small_mag", int'(last_q[0][7:0]), 39, 4);

    load(0, 0, -1, 0);
    run(0, 1, 4, 0, 0, 0, 0);
    chk("neg_relu_q", longint'(last_q[0]), 0);
    run(0, 2, 4, 0, 0, 0, 0);
    chk("neg_acc_model", macc[0], -40);
    chk("neg_lin_q", longint'(last_q[0]), 'h10A);
    run(0, 0, 255, 0, 0, 0, 0);
    chk("tanh_sat_neg_q", longint'(last_q[0]), 'h1FF);

    load(1, 0, 1, 2);
    run(1, 2, 255, 0, 0, 0, 0);
    chk("ragged_acc_model", macc[1], 1787);
    chk("ragged_q", longint'(last_q[1]), 'h0FF);

    load(0, 0, 1, 0);
    run(0, 2, 4, 0, 1, 5, 0);
    chk("stall_q", longint'(last_q[0]), 'h00A);

    for (int k = 0; k < 10; k++) tw[0][k] = 9'd3;
    bd[0] = '0;
    wr[0] = 1'b1;
    st[0] = 1'b1;
    tick();
    wr[0] = 1'b0;
    st[0] = 1'b0;
    chk("wr_beats_start_busy", longint'(bz[0]), 0);
    run(0, 2, 4, 0, 0, 0, 1);
    chk("ignored_wr_q", longint'(last_q[0]), 'h01E);

    load(0, 0, 1, 5);
    am[0] = 2'd2;
    st[0] = 1'b1;
    tick();
    st[0] = 1'b0;
    dd[0] = {5{8'd4}};
    iv[0] = 1'b1;
    tick();
    iv[0] = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("midrun_rst_busy", longint'(bz[0]), 0);
    chk("midrun_rst_q", longint'(qq[0]), 0);
    tick();
    rst_n = 1'b1;
    tick();
    run(0, 2, 4, 0, 0, 0, 0);
    chk("post_rst_q", longint'(last_q[0]), 0);

    for (int it = 0; it < 40; it++) begin
      case ($urandom_range(0, 2))
        0:       wmax = 1;
        1:       wmax = 3;
        default: wmax = 255;
      endcase
      case ($urandom_range(0, 2))
        0:       dmax = 3;
        1:       dmax = 15;
        default: dmax = 255;
      endcase
      b = int'($urandom_range(0, 2 * wmax)) - wmax;
      load(it % 2, 1, wmax, b);
      run(it % 2, int'($urandom_range(0, 3)), -1, dmax, 2,
          int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    end

    tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
